// File: rtl/esc_spi_pkg.sv
// Shared types and helpers for the SPI bus arbiter.
// Frame lengths of zero or above the data width collapse to the data width.
package esc_spi_pkg;

    localparam int SPI_DATA_W = 24;
    localparam int NBITS_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_arb_state_t;

    typedef enum logic {
        REQ_DRV,
        REQ_ADC
    } spi_req_id_t;

    function automatic logic [NBITS_W-1:0] norm_nbits(
        input logic [NBITS_W-1:0] n,
        input logic [NBITS_W-1:0] max_n
    );
        return (n == '0 || n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-1 shifter: SCLK divider, bit counter, MOSI/MISO shift registers.
// A start pulse loads the frame; last_fall pulses once the final low half ends.
module spi_shift_engine
    import esc_spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int SCLK_HALF = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NBITS_W-1:0] nbits,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic [DATA_W-1:0]  rdata,
    output logic               last_fall
);

    localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

    logic               active_q, active_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               last_q, last_d;
    logic [7:0]         half_q, half_d;
    logic [NBITS_W-1:0] left_q, left_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;

    // Half-period timing: rise drives the next MOSI bit, fall captures MISO.
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        last_d   = 1'b0;
        half_d   = half_q;
        left_d   = left_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (start) begin
            active_d = 1'b1;
            sclk_d   = 1'b1;
            mosi_d   = wdata[DATA_W-1];
            tx_d     = wdata << 1;
            rx_d     = '0;
            left_d   = nbits;
            half_d   = '0;
        end else if (active_q) begin
            if (half_q == HALF_LAST) begin
                half_d = '0;
                if (sclk_q) begin
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[DATA_W-2:0], miso};
                    left_d = left_q - NBITS_W'(1);
                end else if (left_q == '0) begin
                    active_d = 1'b0;
                    mosi_d   = 1'b0;
                    last_d   = 1'b1;
                end else begin
                    sclk_d = 1'b1;
                    mosi_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                half_d = half_q + 8'd1;
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            last_q   <= 1'b0;
            half_q   <= '0;
            left_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            last_q   <= last_d;
            half_q   <= half_d;
            left_q   <= left_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign rdata     = rx_q;
    assign last_fall = last_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between gate-driver and ADC register access.
// Define SPI_ARB_RR_EN for round-robin grant; default is fixed DRV priority.
module spi_bus_arbiter
    import esc_spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int SCLK_HALF = 4,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 8
) (
    input  logic               clk_ctrl,
    input  logic               rst_ctrl,
    input  logic               drv_req,
    input  logic [NBITS_W-1:0] drv_nbits,
    input  logic [DATA_W-1:0]  drv_wdata,
    output logic               drv_done,
    output logic [DATA_W-1:0]  drv_rdata,
    input  logic               adc_req,
    input  logic [NBITS_W-1:0] adc_nbits,
    input  logic [DATA_W-1:0]  adc_wdata,
    output logic               adc_done,
    output logic [DATA_W-1:0]  adc_rdata,
    output logic               busy,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               drv_cs_n,
    output logic               adc_cs_n
);

    localparam logic [NBITS_W-1:0] MAX_N      = NBITS_W'(DATA_W);
    localparam logic [7:0]         SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0]         HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0]         GAP_LAST   = 8'(CS_GAP - 1);

    spi_arb_state_t     state_q, state_d;
    spi_req_id_t        id_q, id_d;
    spi_req_id_t        pick;
    logic [NBITS_W-1:0] nbits_q, nbits_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               drv_cs_n_q, drv_cs_n_d;
    logic               adc_cs_n_q, adc_cs_n_d;
    logic               drv_done_q, drv_done_d;
    logic               adc_done_q, adc_done_d;
    logic [DATA_W-1:0]  drv_rdata_q, drv_rdata_d;
    logic [DATA_W-1:0]  adc_rdata_q, adc_rdata_d;
    logic               eng_start;
    logic               eng_last;
    logic [DATA_W-1:0]  eng_rdata;
    logic               fin;
    logic               framing;

`ifdef SPI_ARB_RR_EN
    spi_req_id_t last_grant_q, last_grant_d;

    // Round-robin: a contested grant goes to whoever was not served last.
    always_comb begin
        if (drv_req && adc_req) begin
            pick = (last_grant_q == REQ_DRV) ? REQ_ADC : REQ_DRV;
        end else begin
            pick = drv_req ? REQ_DRV : REQ_ADC;
        end
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (drv_req || adc_req)) begin
            last_grant_d = pick;
        end
    end

    // Remember the most recent grant.
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) last_grant_q <= REQ_ADC;
        else          last_grant_q <= last_grant_d;
    end
`else
    // Fixed priority: the gate driver always wins a contested grant.
    always_comb begin
        pick = drv_req ? REQ_DRV : REQ_ADC;
    end
`endif

    // Frame sequencing, CS decode and per-requester completion.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        nbits_d   = nbits_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q + 8'd1;
        eng_start = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (drv_req || adc_req) begin
                    state_d = SETUP;
                    id_d    = pick;
                    if (pick == REQ_DRV) begin
                        nbits_d = norm_nbits(drv_nbits, MAX_N);
                        wdata_d = drv_wdata;
                    end else begin
                        nbits_d = norm_nbits(adc_nbits, MAX_N);
                        wdata_d = adc_wdata;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    eng_start = 1'b1;
                    state_d   = SHIFT;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                cnt_d = '0;
                if (eng_last) state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    fin     = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        framing     = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        drv_cs_n_d  = !(framing && id_d == REQ_DRV);
        adc_cs_n_d  = !(framing && id_d == REQ_ADC);
        drv_done_d  = fin && (id_q == REQ_DRV);
        adc_done_d  = fin && (id_q == REQ_ADC);
        drv_rdata_d = drv_done_d ? eng_rdata : drv_rdata_q;
        adc_rdata_d = adc_done_d ? eng_rdata : adc_rdata_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            state_q     <= IDLE;
            id_q        <= REQ_DRV;
            nbits_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            drv_cs_n_q  <= 1'b1;
            adc_cs_n_q  <= 1'b1;
            drv_done_q  <= 1'b0;
            adc_done_q  <= 1'b0;
            drv_rdata_q <= '0;
            adc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            nbits_q     <= nbits_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            drv_cs_n_q  <= drv_cs_n_d;
            adc_cs_n_q  <= adc_cs_n_d;
            drv_done_q  <= drv_done_d;
            adc_done_q  <= adc_done_d;
            drv_rdata_q <= drv_rdata_d;
            adc_rdata_q <= adc_rdata_d;
        end
    end

    spi_shift_engine #(
        .DATA_W    (DATA_W),
        .SCLK_HALF (SCLK_HALF)
    ) u_eng (
        .clk       (clk_ctrl),
        .rst       (rst_ctrl),
        .start     (eng_start),
        .nbits     (nbits_q),
        .wdata     (wdata_q),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .rdata     (eng_rdata),
        .last_fall (eng_last)
    );

    assign busy      = (state_q != IDLE);
    assign drv_cs_n  = drv_cs_n_q;
    assign adc_cs_n  = adc_cs_n_q;
    assign drv_done  = drv_done_q;
    assign adc_done  = adc_done_q;
    assign drv_rdata = drv_rdata_q;
    assign adc_rdata = adc_rdata_q;

endmodule
